// File: rtl/blake512_pkg.sv
// ---------------------------------------------------------------------------
// blake512_pkg
// Purpose : Shared constants and types for the BLAKE-512 round scheduler.
//           Holds the message permutation table SIGMA, the 64-bit round
//           constants CB, the default round count, the FSM state enum and
//           the operand/result bundles passed between the operand selector
//           and the G cores.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package blake512_pkg;

  localparam int DEFAULT_ROUNDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Message word permutation; BLAKE-512 reuses rows 0..9 for rounds 10..15.
  localparam logic [3:0] SIGMA [10][16] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,  4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd14, 4'd10, 4'd4,  4'd8,  4'd9,  4'd15, 4'd13, 4'd6,  4'd1,  4'd12, 4'd0,  4'd2,  4'd11, 4'd7,  4'd5,  4'd3},
    '{4'd11, 4'd8,  4'd12, 4'd0,  4'd5,  4'd2,  4'd15, 4'd13, 4'd10, 4'd14, 4'd3,  4'd6,  4'd7,  4'd1,  4'd9,  4'd4},
    '{4'd7,  4'd9,  4'd3,  4'd1,  4'd13, 4'd12, 4'd11, 4'd14, 4'd2,  4'd6,  4'd5,  4'd10, 4'd4,  4'd0,  4'd15, 4'd8},
    '{4'd9,  4'd0,  4'd5,  4'd7,  4'd2,  4'd4,  4'd10, 4'd15, 4'd14, 4'd1,  4'd11, 4'd12, 4'd6,  4'd8,  4'd3,  4'd13},
    '{4'd2,  4'd12, 4'd6,  4'd10, 4'd0,  4'd11, 4'd8,  4'd3,  4'd4,  4'd13, 4'd7,  4'd5,  4'd15, 4'd14, 4'd1,  4'd9},
    '{4'd12, 4'd5,  4'd1,  4'd15, 4'd14, 4'd13, 4'd4,  4'd10, 4'd0,  4'd7,  4'd6,  4'd3,  4'd9,  4'd2,  4'd8,  4'd11},
    '{4'd13, 4'd11, 4'd7,  4'd14, 4'd12, 4'd1,  4'd3,  4'd9,  4'd5,  4'd0,  4'd15, 4'd4,  4'd8,  4'd6,  4'd2,  4'd10},
    '{4'd6,  4'd15, 4'd14, 4'd9,  4'd11, 4'd3,  4'd0,  4'd8,  4'd12, 4'd2,  4'd13, 4'd7,  4'd1,  4'd4,  4'd10, 4'd5},
    '{4'd10, 4'd2,  4'd8,  4'd4,  4'd7,  4'd6,  4'd1,  4'd5,  4'd15, 4'd11, 4'd9,  4'd14, 4'd3,  4'd12, 4'd13, 4'd0}
  };

  // Leading fractional digits of pi, 64 bits each.
  localparam logic [63:0] CB [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] d;
    logic [63:0] m0;
    logic [63:0] m1;
    logic [63:0] k0;
    logic [63:0] k1;
  } g_in_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] d;
  } g_out_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
  } g_idx_t;

  // State word indices touched by a core in a given step. Steps 0/1 are the
  // column G calls, steps 2/3 the diagonal ones; the two cores of one step
  // never share a word, so both results can be written back together.
  function automatic g_idx_t gIndex(input logic [1:0] step, input logic core);
    g_idx_t idx;
    unique case ({step, core})
      3'b000:  idx = '{4'd0, 4'd4, 4'd8,  4'd12};
      3'b001:  idx = '{4'd1, 4'd5, 4'd9,  4'd13};
      3'b010:  idx = '{4'd2, 4'd6, 4'd10, 4'd14};
      3'b011:  idx = '{4'd3, 4'd7, 4'd11, 4'd15};
      3'b100:  idx = '{4'd0, 4'd5, 4'd10, 4'd15};
      3'b101:  idx = '{4'd1, 4'd6, 4'd11, 4'd12};
      3'b110:  idx = '{4'd2, 4'd7, 4'd8,  4'd13};
      default: idx = '{4'd3, 4'd4, 4'd9,  4'd14};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/blake_gcomp.sv
// ---------------------------------------------------------------------------
// blake_gcomp
// Purpose : One BLAKE-512 G function, purely combinational.
// Ports   : i_g  - operands a/b/c/d plus pre-selected message words m0/m1
//                  and constants k0/k1
//           o_g  - updated a/b/c/d
// ---------------------------------------------------------------------------
module blake_gcomp
  import blake512_pkg::*;
(
  input  g_in_t  i_g,
  output g_out_t o_g
);

  logic [63:0] w_a1, w_b1, w_c1, w_d1;
  logic [63:0] w_a2, w_b2, w_c2, w_d2;
  logic [63:0] w_dx1, w_bx1, w_dx2, w_bx2;

  // First half: rotations 32 and 25; second half: 16 and 11 (right rotates).
  always_comb begin
    w_a1  = i_g.a + i_g.b + (i_g.m0 ^ i_g.k1);
    w_dx1 = i_g.d ^ w_a1;
    w_d1  = {w_dx1[31:0], w_dx1[63:32]};
    w_c1  = i_g.c + w_d1;
    w_bx1 = i_g.b ^ w_c1;
    w_b1  = {w_bx1[24:0], w_bx1[63:25]};
    w_a2  = w_a1 + w_b1 + (i_g.m1 ^ i_g.k0);
    w_dx2 = w_d1 ^ w_a2;
    w_d2  = {w_dx2[15:0], w_dx2[63:16]};
    w_c2  = w_c1 + w_d2;
    w_bx2 = w_b1 ^ w_c2;
    w_b2  = {w_bx2[10:0], w_bx2[63:11]};
    o_g   = '{w_a2, w_b2, w_c2, w_d2};
  end

endmodule

// File: rtl/blake_gsel.sv
// ---------------------------------------------------------------------------
// blake_gsel
// Purpose : Combinational operand selector. For the current step and sigma
//           row it picks the state words and message/constant words for the
//           two G cores.
// Ports   : i_step - step within the round (0..3)
//           i_sig  - sigma row (0..9)
//           i_v    - 16x64 state, word i at [64*i +: 64]
//           i_m    - 16x64 message block, same packing
//           o_g0   - operand bundle for core 0
//           o_g1   - operand bundle for core 1
// ---------------------------------------------------------------------------
module blake_gsel
  import blake512_pkg::*;
(
  input  logic [1:0]    i_step,
  input  logic [3:0]    i_sig,
  input  logic [1023:0] i_v,
  input  logic [1023:0] i_m,
  output g_in_t         o_g0,
  output g_in_t         o_g1
);

  logic [3:0] w_sigSafe;

  // G call number is 2*step+core, so its sigma pair starts at {step,core,0}.
  function automatic g_in_t buildOperands(
    input logic [1:0]    step,
    input logic          core,
    input logic [3:0]    sig,
    input logic [1023:0] v,
    input logic [1023:0] m
  );
    g_in_t  g;
    g_idx_t idx;
    logic [3:0] s0, s1;
    idx  = gIndex(step, core);
    s0   = SIGMA[sig][{step, core, 1'b0}];
    s1   = SIGMA[sig][{step, core, 1'b1}];
    g.a  = v[64*idx.a +: 64];
    g.b  = v[64*idx.b +: 64];
    g.c  = v[64*idx.c +: 64];
    g.d  = v[64*idx.d +: 64];
    g.m0 = m[64*s0 +: 64];
    g.m1 = m[64*s1 +: 64];
    g.k0 = CB[s0];
    g.k1 = CB[s1];
    return g;
  endfunction

  // Rows 10..15 cannot occur; folding them onto row 0 keeps the lookup in range.
  always_comb begin
    w_sigSafe = (i_sig > 4'd9) ? 4'd0 : i_sig;
    o_g0 = buildOperands(i_step, 1'b0, w_sigSafe, i_v, i_m);
    o_g1 = buildOperands(i_step, 1'b1, w_sigSafe, i_v, i_m);
  end

endmodule

// File: rtl/blake_round_sched.sv
// ---------------------------------------------------------------------------
// blake_round_sched
// Purpose : Round scheduler for the BLAKE-512 compression core using two G
//           cores. Accepts an initialised state v and message block m, runs
//           ROUNDS rounds at two G calls per cycle (4 cycles per round) and
//           presents the final state. Finalisation happens downstream.
// Ports   : clk       - clock, rising edge
//           rst       - synchronous active-high reset
//           in_valid  - v_in/m_in valid
//           in_ready  - high only while idle
//           v_in      - initial state, v_i = v_in[64*i +: 64]
//           m_in      - message block, m_i = m_in[64*i +: 64]
//           out_valid - v_out holds the final state
//           out_ready - downstream accepts v_out
//           v_out     - state register, same packing as v_in
// ---------------------------------------------------------------------------
module blake_round_sched
  import blake512_pkg::*;
#(
  parameter int ROUNDS = DEFAULT_ROUNDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] v_in,
  input  logic [1023:0] m_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1023:0] v_out
);

  state_t        r_state;
  logic          r_inReady;
  logic          r_outValid;
  logic [1023:0] r_v;
  logic [1023:0] r_m;
  logic [7:0]    r_round;
  logic [1:0]    r_step;
  logic [3:0]    r_sig;

  g_in_t         w_g0In, w_g1In;
  g_out_t        w_g0Out, w_g1Out;
  g_idx_t        w_idx0, w_idx1;
  logic [1023:0] w_vNext;

  blake_gsel u_gsel (
    .i_step (r_step),
    .i_sig  (r_sig),
    .i_v    (r_v),
    .i_m    (r_m),
    .o_g0   (w_g0In),
    .o_g1   (w_g1In)
  );

  blake_gcomp u_g0 (
    .i_g (w_g0In),
    .o_g (w_g0Out)
  );

  blake_gcomp u_g1 (
    .i_g (w_g1In),
    .o_g (w_g1Out)
  );

  // Merge both cores' results into the state; untouched words pass through.
  always_comb begin
    w_idx0  = gIndex(r_step, 1'b0);
    w_idx1  = gIndex(r_step, 1'b1);
    w_vNext = r_v;
    w_vNext[64*w_idx0.a +: 64] = w_g0Out.a;
    w_vNext[64*w_idx0.b +: 64] = w_g0Out.b;
    w_vNext[64*w_idx0.c +: 64] = w_g0Out.c;
    w_vNext[64*w_idx0.d +: 64] = w_g0Out.d;
    w_vNext[64*w_idx1.a +: 64] = w_g1Out.a;
    w_vNext[64*w_idx1.b +: 64] = w_g1Out.b;
    w_vNext[64*w_idx1.c +: 64] = w_g1Out.c;
    w_vNext[64*w_idx1.d +: 64] = w_g1Out.d;
  end

  // Control FSM with counters and data registers. The sigma row tracks the
  // round with its own wrap-at-9 counter instead of a mod-10 divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_v        <= '0;
      r_m        <= '0;
      r_round    <= '0;
      r_step     <= '0;
      r_sig      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_v       <= v_in;
            r_m       <= m_in;
            r_round   <= '0;
            r_step    <= '0;
            r_sig     <= '0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_v    <= w_vNext;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_round <= r_round + 8'd1;
            r_sig   <= (r_sig == 4'd9) ? 4'd0 : r_sig + 4'd1;
            if (r_round == 8'(ROUNDS - 1)) begin
              r_outValid <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign v_out     = r_v;

endmodule

// File: tb/tb_blake_round_sched.sv
// ---------------------------------------------------------------------------
// tb_blake_round_sched
// Purpose : Self-checking bench for blake_round_sched. Expected states come
//           from a word-array model of BLAKE-512 rounds kept in this file.
// ---------------------------------------------------------------------------
module tb_blake_round_sched;

  localparam int ROUNDS  = 16;
  localparam int LATENCY = 4 * ROUNDS;
  localparam int TIMEOUT = 200;

  localparam int SIGMA_TB [10][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
    '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
    '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
    '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
    '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
    '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
    '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
    '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}
  };

  localparam logic [63:0] CB_TB [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  localparam logic [63:0] IV_TB [8] = '{
    64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
    64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
  };

  // The eight G calls of a round in order: four columns then four diagonals.
  localparam int GA [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int GB [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  localparam int GC [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
  localparam int GD [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

  typedef struct {
    string         name;
    logic [1023:0] v;
    logic [1023:0] m;
    logic [1023:0] exp;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] v_in;
  logic [1023:0] m_in;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] v_out;

  int checksRun;
  int checksPassed;

  blake_round_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v_in      (v_in),
    .m_in      (m_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .v_out     (v_out)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Plain BLAKE-512 round function on word arrays.
  function automatic logic [1023:0] modelCompress(input logic [1023:0] vIn, input logic [1023:0] mIn);
    logic [63:0] v [16];
    logic [63:0] m [16];
    logic [1023:0] res;
    for (int i = 0; i < 16; i++) begin
      v[i] = vIn[64*i +: 64];
      m[i] = mIn[64*i +: 64];
    end
    for (int r = 0; r < ROUNDS; r++) begin
      int row;
      row = r % 10;
      for (int g = 0; g < 8; g++) begin
        int x, y;
        x = SIGMA_TB[row][2*g];
        y = SIGMA_TB[row][2*g+1];
        v[GA[g]] = v[GA[g]] + v[GB[g]] + (m[x] ^ CB_TB[y]);
        v[GD[g]] = rotr(v[GD[g]] ^ v[GA[g]], 32);
        v[GC[g]] = v[GC[g]] + v[GD[g]];
        v[GB[g]] = rotr(v[GB[g]] ^ v[GC[g]], 25);
        v[GA[g]] = v[GA[g]] + v[GB[g]] + (m[y] ^ CB_TB[x]);
        v[GD[g]] = rotr(v[GD[g]] ^ v[GA[g]], 16);
        v[GC[g]] = v[GC[g]] + v[GD[g]];
        v[GB[g]] = rotr(v[GB[g]] ^ v[GC[g]], 11);
      end
    end
    for (int i = 0; i < 16; i++) res[64*i +: 64] = v[i];
    return res;
  endfunction

  function automatic logic [1023:0] randBlock();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // One comparison; wide values report the first differing 64-bit word.
  task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int w;
    checksRun++;
    if (act === exp) begin
      checksPassed++;
    end else begin
      w = 0;
      for (int i = 15; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) w = i;
      $display("[TB] FAIL %s word%0d got %h want %h", name, w, act[64*w +: 64], exp[64*w +: 64]);
    end
  endtask

  // Accept one block and wait for out_valid. With junk set, in_valid stays
  // high with fresh random data while the block is busy.
  task automatic applyStimulus(input string name, input logic [1023:0] v, input logic [1023:0] m,
                               input bit junk, output int lat);
    in_valid = 1'b1;
    v_in     = v;
    m_in     = m;
    @(posedge clk); #1;
    checkOutput({name, "_inReadyLow"}, {1023'b0, in_ready}, 1024'd0);
    in_valid = junk;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      if (junk) begin
        v_in = randBlock();
        m_in = randBlock();
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checkOutput({name, "_latency"}, 1024'(lat), 1024'(LATENCY));
  endtask

  // Hold off downstream for a while, then release and confirm return to idle.
  task automatic drainOutput(input string name, input int hold);
    logic [1023:0] held;
    held = v_out;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({name, "_holdValid"}, {1023'b0, out_valid}, 1024'd1);
      checkOutput({name, "_holdData"}, v_out, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_idleInReady"}, {1023'b0, in_ready}, 1024'd1);
    checkOutput({name, "_idleOutValid"}, {1023'b0, out_valid}, 1024'd0);
  endtask

  // Main test sequence.
  initial begin
    vec_t          vecs [4];
    logic [1023:0] goldV, goldM, zeroRes, rv, rm;
    int            lat;

    checksRun    = 0;
    checksPassed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    v_in      = '0;
    m_in      = '0;

    // Golden block: one-byte message 0x00, counter 8 bits, zero salt.
    goldV = '0;
    goldM = '0;
    for (int i = 0; i < 8; i++) goldV[64*i +: 64] = IV_TB[i];
    for (int i = 0; i < 4; i++) goldV[64*(8+i) +: 64] = CB_TB[i];
    goldV[64*12 +: 64] = CB_TB[4] ^ 64'd8;
    goldV[64*13 +: 64] = CB_TB[5] ^ 64'd8;
    goldV[64*14 +: 64] = CB_TB[6];
    goldV[64*15 +: 64] = CB_TB[7];
    goldM[64*0  +: 64] = 64'h0080000000000000;
    goldM[64*13 +: 64] = 64'h0000000000000001;
    goldM[64*15 +: 64] = 64'd8;

    zeroRes = modelCompress('0, '0);
    vecs[0] = '{"zero",   '0,    '0,    zeroRes};
    vecs[1] = '{"golden", goldV, goldM, modelCompress(goldV, goldM)};
    rv = randBlock(); rm = randBlock();
    vecs[2] = '{"randA",  rv,    rm,    modelCompress(rv, rm)};
    rv = randBlock(); rm = randBlock();
    vecs[3] = '{"randB",  rv,    rm,    modelCompress(rv, rm)};

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_inReady", {1023'b0, in_ready}, 1024'd1);
    checkOutput("reset_outValid", {1023'b0, out_valid}, 1024'd0);
    checkOutput("reset_vOut", v_out, 1024'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven blocks.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].name, vecs[i].v, vecs[i].m, 1'b0, lat);
      checkOutput({vecs[i].name, "_vOut"}, v_out, vecs[i].exp);
      drainOutput(vecs[i].name, 0);
    end

    // Backpressure: ten cycles of out_ready low.
    applyStimulus("bp", vecs[2].v, vecs[2].m, 1'b0, lat);
    checkOutput("bp_vOut", v_out, vecs[2].exp);
    drainOutput("bp", 10);

    // Busy ignore: junk on the inputs while running.
    applyStimulus("busy", '0, '0, 1'b1, lat);
    checkOutput("busy_vOut", v_out, zeroRes);
    drainOutput("busy", 2);

    // Reset in the middle of round 7, step 2.
    in_valid = 1'b1;
    v_in     = vecs[3].v;
    m_in     = vecs[3].m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4 * 7 + 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midRst_inReady", {1023'b0, in_ready}, 1024'd1);
    checkOutput("midRst_outValid", {1023'b0, out_valid}, 1024'd0);
    checkOutput("midRst_vOut", v_out, 1024'd0);
    applyStimulus("afterRst", '0, '0, 1'b0, lat);
    checkOutput("afterRst_vOut", v_out, zeroRes);
    drainOutput("afterRst", 0);

    // Randomized blocks against the model.
    for (int i = 0; i < 4; i++) begin
      rv = randBlock();
      rm = randBlock();
      applyStimulus("rand", rv, rm, 1'b0, lat);
      checkOutput("rand_vOut", v_out, modelCompress(rv, rm));
      drainOutput("rand", int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
